// File: rtl/game_pkg.sv
// Shared game-level types and constants used by the timer, score, display and control blocks.
package game_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PLAYING = 2'd1,
    PAUSED  = 2'd2,
    DONE    = 2'd3
  } game_state_t;

  localparam int unsigned GAME_CLK_FREQ    = 50000000;
  localparam int unsigned GAME_MAX_SECONDS = 1800;

endpackage

// File: rtl/second_prescaler.sv
// Divides the system clock down to a one-per-second terminal pulse; holds its count while disabled.
module second_prescaler
  import game_pkg::*;
#(
  parameter int unsigned CLK_FREQ = GAME_CLK_FREQ
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic terminal
);

  localparam int unsigned     CNT_W = (CLK_FREQ > 1) ? $clog2(CLK_FREQ) : 1;
  localparam logic [CNT_W-1:0] TERM = CNT_W'(CLK_FREQ - 1);

  logic [CNT_W-1:0] count;

  assign terminal = en && (count == TERM);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en) begin
      if (terminal) count <= '0;
      else          count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/game_timer.sv
// Elapsed-seconds timer and game state sequencer feeding the score and display logic.
module game_timer
  import game_pkg::*;
#(
  parameter int unsigned CLK_FREQ    = GAME_CLK_FREQ,
  parameter int unsigned TIMER_W     = 11,
  parameter int unsigned MAX_SECONDS = GAME_MAX_SECONDS
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               pause,
  input  logic               finish,
  input  logic               quit,
  output logic [TIMER_W-1:0] timer,
  output logic               playing_condition,
  output logic               tick,
  output logic               time_up,
  output logic [1:0]         state_o
);

  localparam logic [TIMER_W-1:0] LIMIT = TIMER_W'(MAX_SECONDS);

  game_state_t        state, state_n;
  logic [TIMER_W-1:0] timer_n;
  logic               tick_n, time_up_n;
  logic               presc_en, presc_clr, presc_term;

  // Prescaler only advances on a PLAYING cycle not overridden by a higher-priority event,
  // so a pause or finish edge keeps the partial second and discards a coincident terminal.
  assign presc_en  = (state == PLAYING) && !pause && !finish && !quit;
  assign presc_clr = quit || (start && ((state == IDLE) || (state == DONE)));

  second_prescaler #(.CLK_FREQ(CLK_FREQ)) u_prescaler (
    .clk      (clk),
    .rst      (rst),
    .en       (presc_en),
    .clr      (presc_clr),
    .terminal (presc_term)
  );

  always_comb begin
    state_n   = state;
    timer_n   = timer;
    tick_n    = 1'b0;
    time_up_n = time_up;
    if (quit) begin
      state_n   = IDLE;
      timer_n   = '0;
      time_up_n = 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state_n   = PLAYING;
            timer_n   = '0;
            time_up_n = 1'b0;
          end
        end
        PLAYING: begin
          if (finish) begin
            state_n   = DONE;
            time_up_n = 1'b0;
          end else if (pause) begin
            state_n = PAUSED;
          end else if (presc_term) begin
            timer_n = timer + 1'b1;
            tick_n  = 1'b1;
            if (timer_n == LIMIT) begin
              state_n   = DONE;
              time_up_n = 1'b1;
            end
          end
        end
        PAUSED: begin
          if (finish) begin
            state_n   = DONE;
            time_up_n = 1'b0;
          end else if (!pause) begin
            state_n = PLAYING;
          end
        end
        DONE: begin
          if (start) begin
            state_n   = PLAYING;
            timer_n   = '0;
            time_up_n = 1'b0;
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state             <= IDLE;
      timer             <= '0;
      tick              <= 1'b0;
      time_up           <= 1'b0;
      playing_condition <= 1'b0;
    end else begin
      state             <= state_n;
      timer             <= timer_n;
      tick              <= tick_n;
      time_up           <= time_up_n;
      playing_condition <= (state_n != IDLE);
    end
  end

  assign state_o = state;

endmodule

// File: tb/tb_game_timer.sv
// Directed vector bench for game_timer: small-clock instance for sequencing, 1800 s instance for saturation.
module tb_game_timer;

  typedef struct {
    logic        s, p, f, q;
    logic [10:0] t;
    logic        tk;
    logic [1:0]  st;
    logic        pc;
    logic        tu;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0, pause = 1'b0, finish = 1'b0, quit = 1'b0;
  logic [10:0] timer;
  logic        playing_condition, tick, time_up;
  logic [1:0]  state_o;

  logic        start2 = 1'b0, pause2 = 1'b0, finish2 = 1'b0, quit2 = 1'b0;
  logic [10:0] timer2;
  logic        pc2, tick2, tu2;
  logic [1:0]  st2;

  int unsigned nvec  = 0;
  int unsigned nfail = 0;
  vec_t        tbl[256];
  int unsigned ntbl  = 0;

  always #5 clk = ~clk;

  game_timer #(.CLK_FREQ(4), .TIMER_W(11), .MAX_SECONDS(5)) dut (
    .clk(clk), .rst(rst), .start(start), .pause(pause), .finish(finish), .quit(quit),
    .timer(timer), .playing_condition(playing_condition), .tick(tick),
    .time_up(time_up), .state_o(state_o)
  );

  game_timer #(.CLK_FREQ(2), .TIMER_W(11), .MAX_SECONDS(1800)) dut2 (
    .clk(clk), .rst(rst), .start(start2), .pause(pause2), .finish(finish2), .quit(quit2),
    .timer(timer2), .playing_condition(pc2), .tick(tick2),
    .time_up(tu2), .state_o(st2)
  );

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nfail++;
      $display("FAIL %s: got %h, required %h", name, got, exp);
    end
  endtask

  task automatic add(input logic s, p, f, q, input int t, input logic tk,
                     input logic [1:0] st, input logic pc, tu);
    tbl[ntbl].s  = s;  tbl[ntbl].p  = p;  tbl[ntbl].f = f; tbl[ntbl].q = q;
    tbl[ntbl].t  = 11'(t);
    tbl[ntbl].tk = tk; tbl[ntbl].st = st; tbl[ntbl].pc = pc; tbl[ntbl].tu = tu;
    ntbl++;
  endtask

  // One second of PLAYING starting from prescaler 0: three quiet edges, then the tick edge.
  task automatic add_sec(input int tprev);
    for (int k = 0; k < 3; k++) add(0, 0, 0, 0, tprev, 0, 2'd1, 1, 0);
    add(0, 0, 0, 0, tprev + 1, 1, 2'd1, 1, 0);
  endtask

  // Packed view {timer, tick, state, playing, time_up}.
  task automatic step(input vec_t v, input string name);
    start = v.s; pause = v.p; finish = v.f; quit = v.q;
    @(posedge clk); #1;
    chk(name, {16'd0, timer, tick, state_o, playing_condition, time_up},
              {16'd0, v.t, v.tk, v.st, v.pc, v.tu});
  endtask

  initial begin
    int unsigned edges;
    vec_t        hv;

    // IDLE: pause/finish ignored, quit beats start
    add(0, 0, 0, 0, 0, 0, 2'd0, 0, 0);
    add(0, 1, 0, 0, 0, 0, 2'd0, 0, 0);
    add(0, 0, 1, 0, 0, 0, 2'd0, 0, 0);
    add(1, 0, 0, 1, 0, 0, 2'd0, 0, 0);
    add(1, 0, 0, 0, 0, 0, 2'd1, 1, 0);
    for (int sec = 0; sec < 4; sec++) add_sec(sec);
    for (int k = 0; k < 3; k++) add(0, 0, 0, 0, 4, 0, 2'd1, 1, 0);
    add(0, 0, 0, 0, 5, 1, 2'd3, 1, 1);
    // DONE holds; pause and finish ignored
    add(0, 1, 0, 0, 5, 0, 2'd3, 1, 1);
    add(0, 0, 1, 0, 5, 0, 2'd3, 1, 1);
    for (int k = 0; k < 20; k++) add(0, 0, 0, 0, 5, 0, 2'd3, 1, 1);
    // restart, pause at prescaler 2 for 10 cycles (start ignored while paused)
    add(1, 0, 0, 0, 0, 0, 2'd1, 1, 0);
    add(0, 0, 0, 0, 0, 0, 2'd1, 1, 0);
    add(0, 0, 0, 0, 0, 0, 2'd1, 1, 0);
    add(0, 1, 0, 0, 0, 0, 2'd2, 1, 0);
    for (int k = 0; k < 9; k++) add((k == 4) ? 1'b1 : 1'b0, 1, 0, 0, 0, 0, 2'd2, 1, 0);
    add(0, 0, 0, 0, 0, 0, 2'd1, 1, 0);
    add(0, 0, 0, 0, 0, 0, 2'd1, 1, 0);
    add(0, 0, 0, 0, 1, 1, 2'd1, 1, 0);
    // finish on the terminal edge at timer=2: no increment, no tick
    add_sec(1);
    for (int k = 0; k < 3; k++) add(0, 0, 0, 0, 2, 0, 2'd1, 1, 0);
    add(0, 0, 1, 0, 2, 0, 2'd3, 1, 0);
    add(0, 0, 0, 0, 2, 0, 2'd3, 1, 0);
    add(1, 0, 0, 0, 0, 0, 2'd1, 1, 0);
    // quit from PAUSED at timer=3
    for (int sec = 0; sec < 3; sec++) add_sec(sec);
    add(0, 1, 0, 0, 3, 0, 2'd2, 1, 0);
    add(0, 1, 0, 1, 0, 0, 2'd0, 0, 0);
    add(0, 0, 0, 0, 0, 0, 2'd0, 0, 0);
    // start during PLAYING at timer=3 is ignored
    add(1, 0, 0, 0, 0, 0, 2'd1, 1, 0);
    for (int sec = 0; sec < 3; sec++) add_sec(sec);
    add(1, 0, 0, 0, 3, 0, 2'd1, 1, 0);
    add(0, 0, 0, 0, 3, 0, 2'd1, 1, 0);
    add(0, 0, 0, 0, 3, 0, 2'd1, 1, 0);
    add(0, 0, 0, 0, 4, 1, 2'd1, 1, 0);
    // pause on a terminal edge: no tick, prescaler keeps 3
    add(0, 0, 0, 0, 4, 0, 2'd1, 1, 0);
    add(0, 0, 0, 0, 4, 0, 2'd1, 1, 0);
    add(0, 0, 0, 0, 4, 0, 2'd1, 1, 0);
    add(0, 1, 0, 0, 4, 0, 2'd2, 1, 0);
    add(0, 0, 0, 0, 4, 0, 2'd1, 1, 0);

    // reset state
    repeat (2) @(posedge clk);
    #1;
    chk("reset_state", {16'd0, timer, tick, state_o, playing_condition, time_up}, 32'd0);
    chk("reset_dut2", {16'd0, timer2, tick2, st2, pc2, tu2}, 32'd0);
    rst = 1'b0;

    for (int unsigned i = 0; i < ntbl; i++) step(tbl[i], $sformatf("vec%0d", i));

    // async reset between edges while PLAYING at timer=4, prescaler=3
    #3 rst = 1'b1;
    #1;
    chk("async_rst", {16'd0, timer, tick, state_o, playing_condition, time_up}, 32'd0);
    start = 1'b1;
    @(posedge clk); #1;
    chk("rst_over_start", {16'd0, timer, tick, state_o, playing_condition, time_up}, 32'd0);
    start = 1'b0;
    rst   = 1'b0;
    // prescaler must restart from 0 after reset: tick only on the fourth edge
    hv = '{s: 1, p: 0, f: 0, q: 0, t: 11'd0, tk: 0, st: 2'd1, pc: 1, tu: 0};
    step(hv, "post_rst_start");
    hv.s = 0;
    for (int k = 0; k < 3; k++) step(hv, $sformatf("post_rst_q%0d", k));
    hv.t = 11'd1; hv.tk = 1;
    step(hv, "post_rst_tick");

    // 1800-second saturation on the second instance
    start2 = 1'b1;
    @(posedge clk); #1;
    start2 = 1'b0;
    edges  = 1;
    while (st2 != 2'd3 && edges < 4000) begin
      @(posedge clk); #1;
      edges++;
    end
    chk("sat_done_edge", edges, 32'd3601);
    chk("sat_outputs", {16'd0, timer2, tick2, st2, pc2, tu2}, {16'd0, 11'd1800, 1'b1, 2'd3, 1'b1, 1'b1});
    repeat (10) @(posedge clk);
    #1;
    chk("sat_hold", {16'd0, timer2, tick2, st2, pc2, tu2}, {16'd0, 11'd1800, 1'b0, 2'd3, 1'b1, 1'b1});

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule

// File: doc/game_timer.md
Name: game_timer

Overview:
- Produces the elapsed-seconds value and the playing flag that the score block consumes (timer[10:0], playing_condition).
- Runs a per-second prescaler from the system clock and sequences the game through IDLE / PLAYING / PAUSED / DONE.
- DONE is entered when the puzzle is solved or the time limit is reached.
- Sits between the game-control FSM (start/pause/finish/quit pulses) and the score and display logic.

Parameters:
- CLK_FREQ, 50000000: clock cycles per second; prescaler terminal count is CLK_FREQ-1.
- TIMER_W, 11: width of the timer output in seconds.
- MAX_SECONDS, 1800: time limit; reaching it forces DONE with time_up. Must be ≤ 2^TIMER_W-1.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- start  in  1  one-cycle pulse: begin a new game (honoured only in IDLE or DONE)
- pause  in  1  level: while high, PLAYING moves to and stays in PAUSED
- finish  in  1  one-cycle pulse: puzzle solved, freeze time
- quit  in  1  one-cycle pulse: abandon game, return to IDLE
- timer  out  TIMER_W  elapsed whole seconds of the current or last game
- playing_condition  out  1  high in PLAYING, PAUSED and DONE
- tick  out  1  one-cycle pulse on each timer increment
- time_up  out  1  high in DONE when the limit was reached; low when DONE was entered via finish
- state_o  out  2  current state encoding, for display and debug

Behaviour:
- Reset (async, rst=1): state=IDLE, prescaler=0, timer=0, tick=0, time_up=0, playing_condition=0. All outputs are registered.
- Event priority per cycle: quit > finish > start > pause > prescaler terminal.
- IDLE:
  - timer held at 0.
  - start -> PLAYING; prescaler and timer cleared in the same edge.
- PLAYING:
  - prescaler increments each cycle.
  - At CLK_FREQ-1 the prescaler wraps to 0, timer increments, and tick=1 for that one cycle (registered, visible the cycle after the terminal edge).
  - If the increment makes timer == MAX_SECONDS: -> DONE with time_up=1 on the same edge. timer shows MAX_SECONDS and never exceeds it.
  - pause=1 -> PAUSED. The prescaler holds its value (no loss of partial second). No tick in that cycle, even if the terminal count coincides.
  - finish -> DONE with time_up=0. timer frozen at its current value; a coincident terminal count is discarded (no increment, no tick).
- PAUSED:
  - prescaler and timer hold.
  - pause=0 -> PLAYING; counting resumes from the held prescaler value.
  - finish -> DONE with time_up=0.
- DONE:
  - timer, time_up and playing_condition held, so the score stays valid.
  - start -> PLAYING with timer, prescaler and time_up cleared.
- From any state, quit -> IDLE; timer, prescaler and time_up cleared.
- start while in PLAYING or PAUSED is ignored.
- finish in IDLE or DONE is ignored.
- pause in IDLE or DONE is ignored.
- tick is only ever asserted as a result of a PLAYING-state increment.
- Prescaler width is clog2(CLK_FREQ). Arithmetic is unsigned; no wrap of timer is possible because of the MAX_SECONDS stop.
- rst asserted mid-game returns to IDLE immediately, asynchronously, regardless of other inputs.

Decomposition:
- Shared package game_pkg holds:
  - the state typedef/localparams: IDLE=2'd0, PLAYING=2'd1, PAUSED=2'd2, DONE=2'd3 (also used by the display and control FSMs);
  - the default CLK_FREQ;
  - MAX_SECONDS=1800, shared with the score block's upper limit.
- One sub-module, second_prescaler:
  - inputs: clk, rst, en, clr; output: terminal pulse.
  - parameterised by CLK_FREQ.
  - The FSM and timer register live in game_timer.

Test Plan (CLK_FREQ=4, MAX_SECONDS=5 unless noted):
- Reset then start pulse, run 12 cycles -> playing_condition=1; tick pulses every 4 cycles; timer 0→1→2→3; state_o=1.
- Run to limit -> timer stops at 5, state_o=3, time_up=1, playing_condition stays 1; 20 further cycles produce no tick and no change.
- Start, assert pause for 10 cycles at prescaler=2, release -> timer unchanged during pause; next tick arrives 2 cycles after release.
- finish in the same cycle as a prescaler terminal with timer=2 -> DONE, timer=2, time_up=0, no tick. A subsequent start clears timer to 0 and returns to PLAYING.
- In PAUSED with timer=3: quit -> IDLE, timer=0, playing_condition=0. Separately, start during PLAYING with timer=3 -> ignored, timer continues to 4.
- Assert rst asynchronously (between clock edges) during PLAYING with timer=4 -> outputs go to reset values before the next edge. With MAX_SECONDS=1800, TIMER_W=11: timer saturates at 1800.
